// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared types and constants for the hazard/forwarding controller
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } mc_state_t;

    localparam int FSEL_RF  = 0;
    localparam int REGW_DEF = 5;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// rtl/pipe_hazard_ctrl_fwd_sel.sv - priority encoder picking the nearest valid writer of one operand
module pipe_hazard_ctrl_fwd_sel
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int NSRC   = 2,
    parameter int REGW   = REGW_DEF,
    parameter int FSEL_W = $clog2(NSRC + 1)
) (
    input  logic [REGW-1:0]      rs,
    input  logic [NSRC-1:0]      vsrc,
    input  logic [NSRC-1:0]      regwrite,
    input  logic [NSRC*REGW-1:0] rd_src,
    output logic [FSEL_W-1:0]    sel
);

    always_comb begin
        sel = FSEL_W'(FSEL_RF);
        // Walk from the deepest stage up so the nearest match is written last.
        for (int k = NSRC - 1; k >= 0; k--) begin
            if (vsrc[k] && regwrite[k] && (rd_src[k*REGW +: REGW] == rs)) begin
                sel = FSEL_W'(k + 1);
            end
        end
        if (rs == '0) begin
            sel = FSEL_W'(FSEL_RF);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall, flush and forward control with shadow valid chain and multi-cycle execute FSM
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int NSRC   = 2,
    parameter int REGW   = REGW_DEF,
    parameter int MC_LAT = 4,
    parameter int FSEL_W = $clog2(NSRC + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REGW-1:0]      rs1D,
    input  logic [REGW-1:0]      rs2D,
    input  logic [REGW-1:0]      rs1E,
    input  logic [REGW-1:0]      rs2E,
    input  logic [REGW-1:0]      rdE,
    input  logic                 ResultSrcE0,
    input  logic                 PCSrcE,
    input  logic                 mc_startE,
    input  logic [NSRC*REGW-1:0] rd_src,
    input  logic [NSRC-1:0]      regwrite_src,
    output logic [FSEL_W-1:0]    forwardaE,
    output logic [FSEL_W-1:0]    forwardbE,
    output logic                 stallF,
    output logic                 stallD,
    output logic                 flushD,
    output logic                 flushE,
    output logic                 mc_stall,
    output logic                 mc_done,
    output logic                 validE
);

    localparam logic [3:0] CNT_INIT = (MC_LAT > 2) ? 4'(MC_LAT - 3) : 4'd0;

    logic            valid_d;
    logic            valid_e;
    logic [NSRC-1:0] vsrc;
    mc_state_t       state;
    logic [3:0]      cnt;
    logic            lw;
    logic            br;

    pipe_hazard_ctrl_fwd_sel #(.NSRC(NSRC), .REGW(REGW), .FSEL_W(FSEL_W)) u_fwd_a (
        .rs       (rs1E),
        .vsrc     (vsrc),
        .regwrite (regwrite_src),
        .rd_src   (rd_src),
        .sel      (forwardaE)
    );

    pipe_hazard_ctrl_fwd_sel #(.NSRC(NSRC), .REGW(REGW), .FSEL_W(FSEL_W)) u_fwd_b (
        .rs       (rs2E),
        .vsrc     (vsrc),
        .regwrite (regwrite_src),
        .rd_src   (rd_src),
        .sel      (forwardbE)
    );

    assign lw = ResultSrcE0 && valid_e && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));
    assign br = PCSrcE && valid_e;

    // The stall must assert in the same cycle the op is seen in E, so it is decoded, not registered.
    assign mc_stall = ((state == MC_IDLE) && mc_startE && valid_e) || (state == MC_BUSY);
    assign mc_done  = (state == MC_DONE);

    assign stallF = mc_stall || lw;
    assign stallD = mc_stall || lw;
    assign flushE = !mc_stall && (lw || br);
    assign flushD = !mc_stall && br;
    assign validE = valid_e;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_d <= 1'b0;
            valid_e <= 1'b0;
            vsrc    <= '0;
        end else begin
            if (!stallD) begin
                valid_d <= !flushD;
            end
            if (!mc_stall) begin
                valid_e <= flushE ? 1'b0 : valid_d;
                vsrc    <= (vsrc << 1) | NSRC'(valid_e);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= MC_IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                MC_IDLE: begin
                    if (mc_startE && valid_e) begin
                        if (MC_LAT == 2) begin
                            state <= MC_DONE;
                        end else begin
                            state <= MC_BUSY;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                MC_BUSY: begin
                    if (cnt == 4'd0) begin
                        state <= MC_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                MC_DONE: state <= MC_IDLE;
                default: state <= MC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for forwarding, hazards and the multi-cycle FSM
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE;
    logic       ResultSrcE0, PCSrcE, mc_startE;
    logic [9:0] rd_src;
    logic [1:0] regwrite_src;

    logic [1:0] fa4, fb4, fa2, fb2;
    logic       sf4, sd4, fd4, fe4, ms4, md4, ve4;
    logic       sf2, sd2, fd2, fe2, ms2, md2, ve2;

    typedef struct {
        string       tag;
        int          dut;
        logic [10:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  total = 0;
    int  bad   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.NSRC(2), .REGW(5), .MC_LAT(4)) dut4 (
        .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .mc_startE(mc_startE),
        .rd_src(rd_src), .regwrite_src(regwrite_src), .forwardaE(fa4), .forwardbE(fb4),
        .stallF(sf4), .stallD(sd4), .flushD(fd4), .flushE(fe4), .mc_stall(ms4),
        .mc_done(md4), .validE(ve4)
    );

    pipe_hazard_ctrl #(.NSRC(2), .REGW(5), .MC_LAT(2)) dut2 (
        .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .mc_startE(mc_startE),
        .rd_src(rd_src), .regwrite_src(regwrite_src), .forwardaE(fa2), .forwardbE(fb2),
        .stallF(sf2), .stallD(sd2), .flushD(fd2), .flushE(fe2), .mc_stall(ms2),
        .mc_done(md2), .validE(ve2)
    );

    // Packed view: {fa, fb, stallF, stallD, flushD, flushE, mc_stall, mc_done, validE}
    function automatic logic [10:0] mk(input int fa, input int fb, input bit sf, input bit sd,
                                       input bit fd, input bit fe, input bit ms, input bit md,
                                       input bit ve);
        return {2'(fa), 2'(fb), sf, sd, fd, fe, ms, md, ve};
    endfunction

    task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input int dut, input logic [10:0] exp);
        sb_t e;
        e.tag = tag;
        e.dut = dut;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.dut == 2)
                check(e.tag, {fa2, fb2, sf2, sd2, fd2, fe2, ms2, md2, ve2}, e.exp);
            else
                check(e.tag, {fa4, fb4, sf4, sd4, fd4, fe4, ms4, md4, ve4}, e.exp);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] stall_v;
        logic [10:0] zero_v;
        stall_v = mk(0, 0, 1, 1, 0, 0, 1, 0, 1);
        zero_v  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

        reset = 1'b0;
        rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0;
        ResultSrcE0 = 0; PCSrcE = 0; mc_startE = 0;
        rd_src = '0; regwrite_src = '0;
        push("rst4", 4, zero_v);
        push("rst2", 2, zero_v);
        cycle();
        reset = 1'b1;

        rd_src = {5'd5, 5'd5};
        regwrite_src = 2'b11;
        push("fill0", 4, zero_v); cycle();
        push("fill1", 4, zero_v); cycle();
        push("fill2", 4, mk(0, 0, 0, 0, 0, 0, 0, 0, 1)); cycle();
        push("fill3", 4, mk(0, 0, 0, 0, 0, 0, 0, 0, 1)); cycle();

        rs1E = 5;
        push("fwd_m_wins", 4, mk(1, 0, 0, 0, 0, 0, 0, 0, 1)); cycle();
        regwrite_src = 2'b10; rs2E = 5;
        push("fwd_w", 4, mk(2, 2, 0, 0, 0, 0, 0, 0, 1)); cycle();
        rs1E = 0; rs2E = 0; rd_src = '0; regwrite_src = 2'b11;
        push("fwd_x0", 4, mk(0, 0, 0, 0, 0, 0, 0, 0, 1)); cycle();
        rs1E = 6; rs2E = 9; rd_src = {5'd9, 5'd6};
        push("fwd_mixed", 4, mk(1, 2, 0, 0, 0, 0, 0, 0, 1)); cycle();

        rs1E = 0; rs2E = 0;
        ResultSrcE0 = 1; rdE = 7; rs2D = 7;
        push("lw_stall", 4, mk(0, 0, 1, 1, 0, 1, 0, 0, 1)); cycle();
        push("lw_bubble", 4, zero_v); cycle();
        ResultSrcE0 = 0;
        rs1E = 3; rs2E = 4; rd_src = {5'd4, 5'd3}; regwrite_src = 2'b11;
        push("fwd_on_bubble", 4, mk(0, 2, 0, 0, 0, 0, 0, 0, 1)); cycle();

        rs1E = 0; rs2E = 0;
        PCSrcE = 1;
        push("br_flush", 4, mk(0, 0, 0, 0, 1, 1, 0, 0, 1)); cycle();
        push("br_bubble", 4, zero_v); cycle();
        PCSrcE = 0;
        push("br_refill", 4, zero_v); cycle();

        mc_startE = 1; ResultSrcE0 = 1; PCSrcE = 1;
        push("mc_c0", 4, stall_v); cycle();
        push("mc_c1", 4, stall_v); cycle();
        push("mc_c2", 4, stall_v); cycle();
        ResultSrcE0 = 0; PCSrcE = 0;
        push("mc_done", 4, mk(0, 0, 0, 0, 0, 0, 0, 1, 1)); cycle();
        mc_startE = 0;
        push("mc_idle", 4, mk(0, 0, 0, 0, 0, 0, 0, 0, 1)); cycle();

        mc_startE = 1;
        push("busy_c0", 4, stall_v); cycle();
        push("busy_c1", 4, stall_v);
        @(negedge clk);
        drain();
        #2;
        reset = 1'b0;
        mc_startE = 0;
        #1;
        push("async_rst4", 4, zero_v);
        push("async_rst2", 2, zero_v);
        drain();
        @(posedge clk);
        #1;
        reset = 1'b1;
        mc_startE = 1;

        push("re_r0_4", 4, zero_v); push("re_r0_2", 2, zero_v); cycle();
        push("re_r1_4", 4, zero_v); push("re_r1_2", 2, zero_v); cycle();
        push("re_r2_4", 4, stall_v); push("lat2_stall", 2, stall_v); cycle();
        push("re_r3_4", 4, stall_v);
        push("lat2_done", 2, mk(0, 0, 0, 0, 0, 0, 0, 1, 1)); cycle();
        push("re_r4_4", 4, stall_v); push("lat2_again", 2, stall_v); cycle();
        push("re_done4", 4, mk(0, 0, 0, 0, 0, 0, 0, 1, 1));
        push("lat2_done2", 2, mk(0, 0, 0, 0, 0, 0, 0, 1, 1)); cycle();
        mc_startE = 0;
        push("re_idle4", 4, mk(0, 0, 0, 0, 0, 0, 0, 0, 1)); cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
